// File: rtl/dmem_preloader_pkg.sv
// Shared definitions for the data-memory preloader.
//  state_t        loader FSM states
//  CMD_*_DEF      default command byte values
//  FRAME_LEN      bytes in a WRITE frame (cmd, idx, d0..d3)
//  word_byte_addr word index -> byte address
package dmem_preloader_pkg;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_HOLD,
        ST_RUN
    } state_t;

    localparam logic [7:0] CMD_WRITE_DEF = 8'h57;
    localparam logic [7:0] CMD_GO_DEF    = 8'h47;
    localparam int         FRAME_LEN     = 6;
    localparam int         DATA_BYTES    = 4;

    function automatic logic [31:0] word_byte_addr(input logic [29:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/dmem_preloader_if.sv
// Host byte stream plus dmem write port of the preloader.
//  in_valid/in_data/in_ready  byte handshake (transfer = in_valid & in_ready)
//  mem_we/mem_addr/mem_wdata  one-cycle word write to data memory
//  master: host/bench side, slave: the loader
interface dmem_preloader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (output in_valid, in_data,
                    input  in_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input  in_valid, in_data,
                    output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/dmem_preloader_byte_assembler.sv
// Packs 4 bytes little-endian into a 32-bit word (first byte -> [7:0]).
//  clk, reset  clock, async active-low reset
//  shift       accept data_byte this cycle
//  data_byte   incoming byte
//  word        assembled word, held until the next shift
//  done        high on the shift that delivers the 4th byte
module dmem_preloader_byte_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        shift,
    input  logic [7:0]  data_byte,
    output logic [31:0] word,
    output logic        done
);
    logic [1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift) begin
            // Shifting in from the top leaves the first byte at [7:0] after 4 shifts.
            word <= {data_byte, word[31:8]};
            cnt  <= cnt + 2'd1;
        end
    end

    assign done = shift && (cnt == 2'd3);
endmodule

// File: rtl/dmem_preloader.sv
// Byte-stream data-memory preloader. Holds the CPU in reset, turns framed
// WRITE commands (57, idx, d0..d3) into single dmem word writes, and releases
// the CPU HOLD_CYC cycles after a GO (47) command.
//  clk, reset     clock, async active-low reset
//  bus            byte handshake in, dmem write out (slave modport)
//  cpu_reset      active-high CPU reset, low only in RUN
//  err            sticky unknown-command flag
//  words_written  completed WRITE frames, saturating
module dmem_preloader
    import dmem_preloader_pkg::*;
#(
    parameter int         IDX_W     = 8,
    parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF,
    parameter logic [7:0] CMD_GO    = CMD_GO_DEF,
    parameter int         HOLD_CYC  = 4
) (
    input  logic              clk,
    input  logic              reset,
    dmem_preloader_if.slave   bus,
    output logic              cpu_reset,
    output logic              err,
    output logic [15:0]       words_written
);
    state_t      state_q, state_d;
    logic        in_ready, mem_we, xfer;
    logic        asm_shift, asm_done;
    logic [31:0] asm_word;
    logic [IDX_W-1:0] idx_q;
    logic [31:0] cur_addr, last_addr, last_wdata;
    logic [15:0] hold_cnt;

    assign xfer      = bus.in_valid && in_ready;
    assign asm_shift = (state_q == ST_DATA) && bus.in_valid;

    dmem_preloader_byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .shift     (asm_shift),
        .data_byte (bus.in_data),
        .word      (asm_word),
        .done      (asm_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_CMD;
        else        state_q <= state_d;
    end

    // in_valid is used directly per state: ready is known to be 1 in the
    // byte-accepting states, which keeps this block free of a ready loop.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        cpu_reset = 1'b1;
        case (state_q)
            ST_CMD: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_data == CMD_WRITE)   state_d = ST_ADDR;
                    else if (bus.in_data == CMD_GO) state_d = ST_HOLD;
                end
            end
            ST_ADDR: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = ST_DATA;
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (asm_done) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                mem_we  = 1'b1;
                state_d = ST_CMD;
            end
            ST_HOLD: begin
                if (hold_cnt == 16'd0) state_d = ST_RUN;
            end
            ST_RUN: begin
                cpu_reset = 1'b0;
            end
            default: state_d = ST_CMD;
        endcase
    end

    assign cur_addr = word_byte_addr(30'(idx_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q         <= '0;
            last_addr     <= '0;
            last_wdata    <= '0;
            err           <= 1'b0;
            words_written <= '0;
            hold_cnt      <= '0;
        end else begin
            if (state_q == ST_CMD && xfer) begin
                if (bus.in_data == CMD_GO)
                    hold_cnt <= 16'(HOLD_CYC - 1);
                else if (bus.in_data != CMD_WRITE)
                    err <= 1'b1;
            end
            if (state_q == ST_ADDR && xfer)
                idx_q <= IDX_W'(bus.in_data);
            if (state_q == ST_HOLD && hold_cnt != 16'd0)
                hold_cnt <= hold_cnt - 16'd1;
            if (state_q == ST_WRITE) begin
                last_addr  <= cur_addr;
                last_wdata <= asm_word;
                if (words_written != 16'hFFFF)
                    words_written <= words_written + 16'd1;
            end
        end
    end

    // Address/data show the new frame only during WRITE and otherwise hold
    // the last written pair.
    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = (state_q == ST_WRITE) ? cur_addr : last_addr;
    assign bus.mem_wdata = (state_q == ST_WRITE) ? asm_word : last_wdata;
endmodule

// File: tb/tb_dmem_preloader.sv
module tb_dmem_preloader;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_reset, err;
    logic [15:0] words_written;

    dmem_preloader_if bus ();

    dmem_preloader #(.IDX_W(8), .HOLD_CYC(HOLD)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .cpu_reset     (cpu_reset),
        .err           (err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dut_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect accepted bytes, emit a write one cycle after
    // the 6th byte, count down GO hold cycles.
    int          m_n;
    logic [7:0]  m_fr [6];
    bit          m_we, m_go, m_err;
    int          m_left, m_cnt;
    logic [31:0] m_addr, m_data, m_last_addr, m_last_data;
    logic        exp_ready, exp_cpu, m_xfer;

    task automatic model_reset();
        m_n = 0; m_we = 0; m_go = 0; m_err = 0; m_left = 0; m_cnt = 0;
        m_addr = 0; m_data = 0; m_last_addr = 0; m_last_data = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_ready", 32'(bus.in_ready), 1);
            chk("rst_we", 32'(bus.mem_we), 0);
            chk("rst_addr", bus.mem_addr, 0);
            chk("rst_wdata", bus.mem_wdata, 0);
            chk("rst_cpu", 32'(cpu_reset), 1);
            chk("rst_err", 32'(err), 0);
            chk("rst_cnt", 32'(words_written), 0);
            model_reset();
        end else begin
            exp_ready = !m_we && !m_go;
            exp_cpu   = !(m_go && m_left == 0);
            chk("ready", 32'(bus.in_ready), 32'(exp_ready));
            chk("we", 32'(bus.mem_we), 32'(m_we));
            chk("addr", bus.mem_addr, m_we ? m_addr : m_last_addr);
            chk("wdata", bus.mem_wdata, m_we ? m_data : m_last_data);
            chk("cpu_reset", 32'(cpu_reset), 32'(exp_cpu));
            chk("err", 32'(err), 32'(m_err));
            chk("count", 32'(words_written), 32'(m_cnt));
            if (bus.mem_we) dut_pulses++;

            m_xfer = bus.in_valid && exp_ready;
            if (m_we) begin
                m_last_addr = m_addr;
                m_last_data = m_data;
                if (m_cnt < 65535) m_cnt++;
                m_we = 0;
            end else if (m_go) begin
                if (m_left > 0) m_left--;
            end else if (m_xfer) begin
                if (m_n == 0) begin
                    if (bus.in_data == 8'h57) begin
                        m_fr[0] = bus.in_data;
                        m_n = 1;
                    end else if (bus.in_data == 8'h47) begin
                        m_go = 1;
                        m_left = HOLD;
                    end else begin
                        m_err = 1;
                    end
                end else begin
                    m_fr[m_n] = bus.in_data;
                    m_n++;
                    if (m_n == 6) begin
                        m_we   = 1;
                        m_addr = 32'(m_fr[1]) * 4;
                        m_data = {m_fr[5], m_fr[4], m_fr[3], m_fr[2]};
                        m_n    = 0;
                    end
                end
            end
        end
    end

    // Driver tasks start and end at posedge+1.
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_byte timeout actual=no_ready required=ready byte=%0h", b);
        end
    endtask

    task automatic send_frame(input logic [7:0] idx, input logic [31:0] d,
                              input int gmin, input int gmax);
        logic [7:0] b [6];
        b[0] = 8'h57; b[1] = idx;
        b[2] = d[7:0]; b[3] = d[15:8]; b[4] = d[23:16]; b[5] = d[31:24];
        for (int i = 0; i < 6; i++) begin
            send_byte(b[i]);
            idle(int'($urandom_range(gmax, gmin)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, hi;
        bit fin;
        logic [7:0] junk;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        idle(5);
        chk("idle_ready", 32'(bus.in_ready), 1);
        chk("idle_cpu", 32'(cpu_reset), 1);
        chk("idle_pulses", dut_pulses, 0);
        chk("idle_count", 32'(words_written), 0);

        send_frame(8'h01, 32'h0000_0042, 0, 0);
        idle(2);
        chk("f1_pulses", dut_pulses, 1);
        chk("f1_addr", bus.mem_addr, 32'h4);
        chk("f1_data", bus.mem_wdata, 32'd66);
        chk("f1_count", 32'(words_written), 1);

        send_frame(8'h02, 32'h0000_0079, 0, 0);
        idle(2);
        chk("f2_addr", bus.mem_addr, 32'h8);
        chk("f2_data", bus.mem_wdata, 32'd121);
        chk("f2_count", 32'(words_written), 2);

        send_frame(8'h03, 32'h0000_0099, 1, 1);
        idle(2);
        chk("sparse_pulses", dut_pulses, 3);
        chk("sparse_addr", bus.mem_addr, 32'hC);
        chk("sparse_data", bus.mem_wdata, 32'h99);

        send_byte(8'h13);
        idle(1);
        chk("bad_err", 32'(err), 1);
        send_frame(8'h04, 32'h1234_5678, 0, 0);
        idle(2);
        chk("after_err_count", 32'(words_written), 4);
        chk("after_err_data", bus.mem_wdata, 32'h1234_5678);
        chk("after_err_err", 32'(err), 1);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(5, 0) == 0) begin
                junk = 8'($urandom);
                if (junk == 8'h57 || junk == 8'h47) junk = 8'h13;
                send_byte(junk);
            end
            send_frame(8'($urandom), $urandom, 0, 2);
        end
        idle(3);

        send_byte(8'h57); send_byte(8'h05); send_byte(8'hEF); send_byte(8'hBE);
        reset = 1'b0;
        #1;
        chk("midrst_cpu", 32'(cpu_reset), 1);
        chk("midrst_count", 32'(words_written), 0);
        idle(2);
        reset = 1'b1;
        idle(1);
        p0 = dut_pulses;
        send_frame(8'h05, 32'hDEAD_BEEF, 0, 0);
        idle(2);
        chk("midrst_pulses", dut_pulses, p0 + 1);
        chk("midrst_addr", bus.mem_addr, 32'h14);
        chk("midrst_data", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("midrst_fcount", 32'(words_written), 1);

        p0 = dut_pulses;
        send_byte(8'h47);
        hi = 0; fin = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) chk("go_ready", 32'(bus.in_ready), 0);
            if (!fin) begin
                if (cpu_reset) hi++;
                else fin = 1;
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_data  = (k % 2 == 0) ? 8'h57 : 8'($urandom);
        end
        bus.in_valid = 1'b0;
        chk("go_hold_cycles", hi, HOLD);
        chk("go_cpu_low", 32'(cpu_reset), 0);
        chk("go_no_write", dut_pulses, p0);

        reset = 1'b0;
        #1;
        chk("run_rst_cpu", 32'(cpu_reset), 1);
        idle(2);
        reset = 1'b1;
        idle(2);
        chk("run_rst_ready", 32'(bus.in_ready), 1);
        chk("run_rst_cpu2", 32'(cpu_reset), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
